// File: rtl/pipe_hazard_unit.sv
// -----------------------------------------------------------------------------
// pipe_hazard_unit
//
// Hazard detection and resolution for a classic 5-stage in-order pipeline
// (IF / ID / EX / MEM / WB). The block:
//   * selects EX operand forwarding sources (EX/MEM or MEM/WB over regfile),
//   * detects load-use hazards (or, with forwarding disabled, any RAW hazard
//     against an instruction still in EX or MEM),
//   * holds the front of the pipe while a multi-cycle op occupies EX,
//   * flushes the three younger stages on a taken branch resolved in MEM,
//   * counts stall cycles and branch flushes with saturating counters.
//
// Parameters
//   REG_AW  : register-address width
//   MUL_LAT : EX-stage cycles of a multi-cycle op (1..16)
//   FWD_EN  : 1 = forwarding enabled, 0 = every RAW hazard stalls
//   CNT_W   : performance-counter width
//
// Ports
//   clk, rst                      : clock (rising edge), async active-low reset
//   id_rs, id_rt, id_use_rs/rt    : ID-stage source registers and read flags
//   ex_rs, ex_rt, ex_rd           : ID/EX register fields
//   ex_regwrite/memread/is_mul    : ID/EX control
//   mem_rd, mem_regwrite          : EX/MEM destination
//   wb_rd, wb_regwrite            : MEM/WB destination
//   branch_taken                  : branch resolved taken in MEM
//   pc_en, ifid_en, idex_en       : stage-register load enables
//   ifid/idex/exmem_flush         : bubble insertion
//   fwd_a, fwd_b                  : 00 regfile, 10 EX/MEM, 01 MEM/WB
//   stall_cnt, flush_cnt          : saturating performance counters
// -----------------------------------------------------------------------------
module pipe_hazard_unit #(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 4,
  parameter int FWD_EN  = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              ex_is_mul,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  input  logic              branch_taken,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  localparam logic       MUL_MULTI = (MUL_LAT > 1);
  localparam logic       STALL_ALL = (FWD_EN == 0);
  // The first stall cycle is spent in IDLE, so BUSY counts down from LAT-2.
  localparam logic [3:0] MCNT_INIT = MUL_MULTI ? 4'(MUL_LAT - 2) : 4'd0;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  state_e           r_state;
  logic [3:0]       r_mcnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  state_e     w_state_nxt;
  logic [3:0] w_mcnt_nxt;
  logic       w_mul_stall;
  logic       w_hit_ex;
  logic       w_hit_mem;
  logic       w_lu;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_pc_en;
  logic       w_ifid_en;
  logic       w_idex_en;
  logic       w_ifid_flush;
  logic       w_idex_flush;
  logic       w_exmem_flush;

  // ---------------------------------------------------------------------------
  // Forwarding: the younger producer (EX/MEM) wins over MEM/WB; r0 never
  // forwards because it is hard-wired to zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_fwd_a = FWD_RF;
    w_fwd_b = FWD_RF;
    if (!STALL_ALL) begin
      if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs))
        w_fwd_a = FWD_MEM;
      else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs))
        w_fwd_a = FWD_WB;

      if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rt))
        w_fwd_b = FWD_MEM;
      else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rt))
        w_fwd_b = FWD_WB;
    end
  end

  // ---------------------------------------------------------------------------
  // RAW detection against the ID instruction's sources. Without forwarding,
  // producers in EX and MEM must also drain; WB needs no stall because the
  // register file writes before it reads.
  // ---------------------------------------------------------------------------
  assign w_hit_ex  = (ex_rd != '0) &&
                     ((id_use_rs && (ex_rd == id_rs)) ||
                      (id_use_rt && (ex_rd == id_rt)));
  assign w_hit_mem = (mem_rd != '0) &&
                     ((id_use_rs && (mem_rd == id_rs)) ||
                      (id_use_rt && (mem_rd == id_rt)));

  assign w_lu = (ex_memread && w_hit_ex) ||
                (STALL_ALL && ((ex_regwrite && w_hit_ex) ||
                               (mem_regwrite && w_hit_mem)));

  // ---------------------------------------------------------------------------
  // Multi-cycle FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_mcnt  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_state <= w_state_nxt;
      r_mcnt  <= w_mcnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Multi-cycle FSM: next-state logic. A taken branch squashes the op in EX,
  // so the FSM is forced back to IDLE with a clear counter.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_mcnt_nxt  = r_mcnt;
    if (branch_taken) begin
      w_state_nxt = S_IDLE;
      w_mcnt_nxt  = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (ex_is_mul && MUL_MULTI) begin
            w_state_nxt = S_BUSY;
            w_mcnt_nxt  = MCNT_INIT;
          end
        end
        S_BUSY: begin
          if (r_mcnt != '0) begin
            w_mcnt_nxt = r_mcnt - 4'd1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_mcnt_nxt  = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Multi-cycle FSM: output logic. Gated by rst so an op sitting in EX while
  // reset is held cannot present a stall.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_mul_stall = 1'b0;
    unique case (r_state)
      S_IDLE:  w_mul_stall = ex_is_mul && MUL_MULTI;
      S_BUSY:  w_mul_stall = (r_mcnt != '0);
      default: w_mul_stall = 1'b0;
    endcase
    w_mul_stall = w_mul_stall && rst;
  end

  // ---------------------------------------------------------------------------
  // Stage control, priority: branch > multi-cycle stall > load-use > normal.
  // The multi-cycle stall freezes IF/ID/EX and bubbles MEM; a load-use stall
  // freezes IF/ID and lets a bubble into EX.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_pc_en       = 1'b1;
    w_ifid_en     = 1'b1;
    w_idex_en     = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_flush = 1'b0;
    if (branch_taken) begin
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
      w_exmem_flush = 1'b1;
    end else if (w_mul_stall) begin
      w_pc_en       = 1'b0;
      w_ifid_en     = 1'b0;
      w_idex_en     = 1'b0;
      w_exmem_flush = 1'b1;
    end else if (w_lu) begin
      w_pc_en       = 1'b0;
      w_ifid_en     = 1'b0;
      w_idex_flush  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_pc_en && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (branch_taken && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign pc_en       = w_pc_en;
  assign ifid_en     = w_ifid_en;
  assign idex_en     = w_idex_en;
  assign ifid_flush  = w_ifid_flush;
  assign idex_flush  = w_idex_flush;
  assign exmem_flush = w_exmem_flush;
  assign fwd_a       = w_fwd_a;
  assign fwd_b       = w_fwd_b;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_unit
//
// Directed bench for pipe_hazard_unit. Four instances share the pipeline
// inputs:
//   dut    : defaults (forwarding on, MUL_LAT=4, 16-bit counters)
//   dut_nf : FWD_EN=0
//   dut_m1 : MUL_LAT=1
//   dut_sf : CNT_W=2, on its own reset, used for counter saturation
// Inputs change 1 ns after a rising edge, outputs are read 1 ns later.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_unit;

  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          rst_sf;
  logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic          id_use_rs, id_use_rt;
  logic          ex_regwrite, ex_memread, ex_is_mul;
  logic          mem_regwrite, wb_regwrite, branch_taken;

  logic        pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  logic        nf_pc_en, nf_ifid_en, nf_idex_en;
  logic        nf_ifid_flush, nf_idex_flush, nf_exmem_flush;
  logic [1:0]  nf_fwd_a, nf_fwd_b;
  logic [15:0] nf_stall_cnt, nf_flush_cnt;

  logic        m1_pc_en, m1_ifid_en, m1_idex_en;
  logic        m1_ifid_flush, m1_idex_flush, m1_exmem_flush;
  logic [1:0]  m1_fwd_a, m1_fwd_b;
  logic [15:0] m1_stall_cnt, m1_flush_cnt;

  logic        sf_pc_en, sf_ifid_en, sf_idex_en;
  logic        sf_ifid_flush, sf_idex_flush, sf_exmem_flush;
  logic [1:0]  sf_fwd_a, sf_fwd_b;
  logic [1:0]  sf_stall_cnt, sf_flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_hazard_unit dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_is_mul(ex_is_mul),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .branch_taken(branch_taken),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_unit #(.FWD_EN(0)) dut_nf (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_is_mul(ex_is_mul),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .branch_taken(branch_taken),
    .pc_en(nf_pc_en), .ifid_en(nf_ifid_en), .idex_en(nf_idex_en),
    .ifid_flush(nf_ifid_flush), .idex_flush(nf_idex_flush),
    .exmem_flush(nf_exmem_flush), .fwd_a(nf_fwd_a), .fwd_b(nf_fwd_b),
    .stall_cnt(nf_stall_cnt), .flush_cnt(nf_flush_cnt)
  );

  pipe_hazard_unit #(.MUL_LAT(1)) dut_m1 (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_is_mul(ex_is_mul),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .branch_taken(branch_taken),
    .pc_en(m1_pc_en), .ifid_en(m1_ifid_en), .idex_en(m1_idex_en),
    .ifid_flush(m1_ifid_flush), .idex_flush(m1_idex_flush),
    .exmem_flush(m1_exmem_flush), .fwd_a(m1_fwd_a), .fwd_b(m1_fwd_b),
    .stall_cnt(m1_stall_cnt), .flush_cnt(m1_flush_cnt)
  );

  pipe_hazard_unit #(.CNT_W(2)) dut_sf (
    .clk(clk), .rst(rst_sf),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_is_mul(ex_is_mul),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .branch_taken(branch_taken),
    .pc_en(sf_pc_en), .ifid_en(sf_ifid_en), .idex_en(sf_idex_en),
    .ifid_flush(sf_ifid_flush), .idex_flush(sf_idex_flush),
    .exmem_flush(sf_exmem_flush), .fwd_a(sf_fwd_a), .fwd_b(sf_fwd_b),
    .stall_cnt(sf_stall_cnt), .flush_cnt(sf_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_rs = '0; ex_rt = '0; ex_rd = '0;
    ex_regwrite = 1'b0; ex_memread = 1'b0; ex_is_mul = 1'b0;
    mem_rd = '0; mem_regwrite = 1'b0; wb_rd = '0; wb_regwrite = 1'b0;
    branch_taken = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst    = 1'b1;
    rst_sf = 1'b1;
    #1;
    rst    = 1'b0;
    rst_sf = 1'b0;
    // A multi-cycle op in EX during reset must not stall.
    ex_is_mul = 1'b1;
    #1;
    check("rst_stall_cnt", 32'(stall_cnt), 0);
    check("rst_flush_cnt", 32'(flush_cnt), 0);
    check("rst_pc_en_mul", 32'(pc_en), 1);
    check("rst_exmem_flush", 32'(exmem_flush), 0);
    check("rst_fwd_a", 32'(fwd_a), 0);
    ex_is_mul = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();

    // ---- Forwarding select ----
    ex_rs = 5'd3; mem_rd = 5'd3; mem_regwrite = 1'b1; wb_rd = 5'd3; wb_regwrite = 1'b1;
    #1;
    check("fwd_a_mem", 32'(fwd_a), 32'b10);
    check("nf_fwd_a_off", 32'(nf_fwd_a), 32'b00);
    mem_regwrite = 1'b0;
    #1;
    check("fwd_a_wb", 32'(fwd_a), 32'b01);
    ex_rs = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0; mem_regwrite = 1'b1;
    #1;
    check("fwd_a_r0", 32'(fwd_a), 32'b00);
    ex_rt = 5'd9; wb_rd = 5'd9; mem_rd = 5'd4;
    #1;
    check("fwd_b_wb", 32'(fwd_b), 32'b01);
    mem_rd = 5'd9;
    #1;
    check("fwd_b_mem", 32'(fwd_b), 32'b10);
    clear_inputs();
    tick();
    check("fwd_no_stall_cnt", 32'(stall_cnt), 0);

    // ---- Load-use stall ----
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    #1;
    check("lu_pc_en", 32'(pc_en), 0);
    check("lu_ifid_en", 32'(ifid_en), 0);
    check("lu_idex_en", 32'(idex_en), 1);
    check("lu_idex_flush", 32'(idex_flush), 1);
    check("lu_exmem_flush", 32'(exmem_flush), 0);
    tick();
    clear_inputs();
    #1;
    check("lu_release", 32'(pc_en), 1);
    check("lu_stall_cnt", 32'(stall_cnt), 1);
    id_use_rs = 1'b1; id_rs = 5'd5; ex_rd = 5'd5; ex_regwrite = 1'b1;
    #1;
    check("alu_no_lu_fwd", 32'(pc_en), 1);
    clear_inputs();

    // ---- Multi-cycle op, MUL_LAT=4: three stalls, released on the 4th ----
    ex_is_mul = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check($sformatf("mul_pc_en_c%0d", c), 32'(pc_en), (c < 4) ? 1'b0 : 1'b1);
      check($sformatf("mul_exmem_c%0d", c), 32'(exmem_flush), (c < 4) ? 1'b1 : 1'b0);
      check($sformatf("mul_idex_en_c%0d", c), 32'(idex_en), (c < 4) ? 1'b0 : 1'b1);
      if (c == 1) check("m1_no_stall", 32'(m1_pc_en), 1);
      tick();
    end
    ex_is_mul = 1'b0;
    #1;
    check("mul_after_idle", 32'(pc_en), 1);
    check("mul_stall_cnt", 32'(stall_cnt), 4);
    check("m1_stall_cnt", 32'(m1_stall_cnt), 1);  // only the load-use stall

    // ---- Branch in the 2nd BUSY cycle ----
    ex_is_mul = 1'b1;
    #1;
    check("br_idle_stall", 32'(pc_en), 0);
    tick();
    check("br_busy1_stall", 32'(pc_en), 0);
    tick();
    branch_taken = 1'b1;
    #1;
    check("br_pc_en", 32'(pc_en), 1);
    check("br_ifid_flush", 32'(ifid_flush), 1);
    check("br_idex_flush", 32'(idex_flush), 1);
    check("br_exmem_flush", 32'(exmem_flush), 1);
    tick();
    branch_taken = 1'b0; ex_is_mul = 1'b0;
    #1;
    check("br_post1", 32'(pc_en), 1);
    tick();
    check("br_post2", 32'(pc_en), 1);
    check("br_stall_cnt", 32'(stall_cnt), 6);
    check("br_flush_cnt", 32'(flush_cnt), 1);

    // ---- Branch in the 1st BUSY cycle: counter must be cleared ----
    ex_is_mul = 1'b1;
    tick();
    branch_taken = 1'b1; ex_is_mul = 1'b0;
    tick();
    branch_taken = 1'b0;
    #1;
    check("br1_post1", 32'(pc_en), 1);
    tick();
    check("br1_post2", 32'(pc_en), 1);
    check("br1_stall_cnt", 32'(stall_cnt), 7);
    check("br1_flush_cnt", 32'(flush_cnt), 2);

    // ---- Reset mid-BUSY ----
    ex_is_mul = 1'b1;
    tick();
    ex_is_mul = 1'b0;
    #1;
    check("rb_busy_stall", 32'(pc_en), 0);
    rst = 1'b0;
    #1;
    check("rb_abort", 32'(pc_en), 1);
    check("rb_stall_cnt", 32'(stall_cnt), 0);
    check("rb_flush_cnt", 32'(flush_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("rb_post1", 32'(pc_en), 1);
    tick();
    check("rb_post2", 32'(pc_en), 1);
    check("rb_post_cnt", 32'(stall_cnt), 0);

    // ---- FWD_EN=0: every RAW stalls ----
    ex_regwrite = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_use_rt = 1'b1;
    ex_rt = 5'd7; mem_rd = 5'd7; mem_regwrite = 1'b1;
    #1;
    check("nf_ex_pc_en", 32'(nf_pc_en), 0);
    check("nf_ex_idex_flush", 32'(nf_idex_flush), 1);
    check("nf_fwd_b", 32'(nf_fwd_b), 0);
    check("fe_fwd_b", 32'(fwd_b), 32'b10);
    check("fe_no_stall", 32'(pc_en), 1);
    ex_regwrite = 1'b0;
    #1;
    check("nf_mem_stall", 32'(nf_pc_en), 0);
    mem_regwrite = 1'b0; wb_rd = 5'd7; wb_regwrite = 1'b1;
    #1;
    check("nf_wb_no_stall", 32'(nf_pc_en), 1);
    clear_inputs();

    // ---- Counter saturation, CNT_W=2 ----
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    rst_sf = 1'b1;
    tick();
    tick();
    check("sat_pre", 32'(sf_stall_cnt), 2);
    tick();
    tick();
    tick();
    check("sat_hold", 32'(sf_stall_cnt), 3);
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
